// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: arbiter state type, default widths and timeout counter sizing for mult_share_arbiter
package mult_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_TIMEOUT_CYC = 64;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mult_rr_pick.sv
// mult_rr_pick: combinational round-robin picker, first eligible requester at or above ptr with wrap
module mult_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // scan offsets from far to near so the smallest offset from ptr is the one left in idx
  always_comb begin
    valid = |elig;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (elig[j]) idx = j;
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one sequential multiplier between NUM_REQ requesters; MULT_ARB_TIMEOUT_EN adds a WAIT timeout
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     SYS_CLOCK,
  input  logic                     SYS_SRESET,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_A,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_B,
  output logic [NUM_REQ-1:0]        ACK,
  output logic [2*DATA_W-1:0]       RESULT,
  output logic                     ERR,
  output logic                     BUSY,
  output logic [IW-1:0]            GRANT_ID,
  output logic                     MULT_GO,
  output logic [DATA_W-1:0]        MULT_A,
  output logic [DATA_W-1:0]        MULT_B,
  input  logic                     MULT_START,
  input  logic                     MULT_DONE,
  input  logic [2*DATA_W-1:0]       MULT_F
);
  arb_state_t state, nxt;
  logic [IW-1:0] ptr, win;
  logic [NUM_REQ-1:0] elig;
  logic win_ok, grant, to_hit, to_q;
  assign elig = REQ & ~ACK;
  assign grant = state == IDLE && win_ok && MULT_START;
  mult_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .elig(elig),
    .ptr(ptr),
    .valid(win_ok),
    .idx(win)
  );
  // state register
  always_ff @(posedge SYS_CLOCK) state <= SYS_SRESET ? IDLE : nxt;
  // next state, GO pulse and busy decode
  always_comb begin
    nxt = state;
    MULT_GO = 1'b0;
    BUSY = state != IDLE;
    case (state)
      IDLE: nxt = grant ? ISSUE : IDLE;
      ISSUE: begin
        nxt = WAIT;
        MULT_GO = 1'b1;
      end
      WAIT: nxt = (MULT_DONE || to_hit) ? RESP : WAIT;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // operand capture at grant, response and pointer update on leaving RESP
  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_SRESET) begin
      ptr <= '0;
      GRANT_ID <= '0;
      MULT_A <= '0;
      MULT_B <= '0;
      ACK <= '0;
      RESULT <= '0;
      ERR <= 1'b0;
    end else begin
      ACK <= '0;
      ERR <= 1'b0;
      if (grant) begin
        GRANT_ID <= win;
        MULT_A <= REQ_A[win*DATA_W +: DATA_W];
        MULT_B <= REQ_B[win*DATA_W +: DATA_W];
      end
      if (state == RESP) begin
        ACK <= NUM_REQ'(1) << GRANT_ID;
        RESULT <= to_q ? '0 : MULT_F;
        ERR <= to_q;
        ptr <= (GRANT_ID == IW'(NUM_REQ - 1)) ? '0 : GRANT_ID + 1'b1;
      end
    end
  end
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = cnt_w(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  assign to_hit = !MULT_DONE && cnt == CW'(TIMEOUT_CYC - 1);
  // WAIT-cycle counter, zeroed in ISSUE so the first WAIT cycle counts from zero; a real DONE beats the timeout
  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_SRESET || state == ISSUE) begin
      cnt <= '0;
      to_q <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
      to_q <= to_hit;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = TIMEOUT_CYC > 0;
  assign to_hit = 1'b0;
  assign to_q = 1'b0;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and randomized checks of mult_share_arbiter against a deadline-based transaction model
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int W = 3;
  localparam int TO = 64;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] req = 0;
  logic [N*W-1:0] req_a = 0;
  logic [N*W-1:0] req_b = 0;
  logic [N-1:0] ack;
  logic [2*W-1:0] result;
  logic err, busy, mult_go;
  logic [1:0] grant_id;
  logic [W-1:0] mult_a, mult_b;
  logic mult_start = 0;
  logic mult_done = 0;
  logic [2*W-1:0] mult_f = 0;
  int cyc_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit start_en = 1;
  bit hang = 0;
  bit noise_en = 0;

  mult_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .SYS_CLOCK(clk),
    .SYS_SRESET(rst),
    .REQ(req),
    .REQ_A(req_a),
    .REQ_B(req_b),
    .ACK(ack),
    .RESULT(result),
    .ERR(err),
    .BUSY(busy),
    .GRANT_ID(grant_id),
    .MULT_GO(mult_go),
    .MULT_A(mult_a),
    .MULT_B(mult_b),
    .MULT_START(mult_start),
    .MULT_DONE(mult_done),
    .MULT_F(mult_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
    end
  endtask

  // Behavioural multiplier: zero operand finishes one cycle after GO, otherwise 2..5 cycles;
  // F shows the product the cycle after DONE and garbage whenever idle; optional stray DONEs while idle.
  bit mu_busy = 0;
  int mu_done_at = -1;
  logic [2*W-1:0] mu_prod = 0;
  always begin
    bit nd, nf, ns, nz;
    @(negedge clk);
    if (rst) mu_busy = 0;
    else if (mult_go) begin
      mu_busy = 1;
      mu_prod = mult_a * mult_b;
      mu_done_at = cyc_n + ((mult_a == 0 || mult_b == 0) ? 1 : int'($urandom_range(2, 5)));
    end
    nd = mu_busy && !hang && cyc_n + 1 == mu_done_at;
    nf = mu_busy && !hang && cyc_n == mu_done_at;
    if (nf) mu_busy = 0;
    ns = !mu_busy && start_en;
    nz = !mu_busy && noise_en && $urandom_range(0, 3) == 0;
    @(posedge clk);
    #1;
    mult_done = nd || nz;
    mult_start = ns;
    mult_f = nf ? mu_prod : (mu_busy ? mult_f : 6'($urandom));
  end

  // Transaction model: one job at a time, GO the cycle after the grant decision, response the cycle
  // after DONE is seen in a waiting cycle, ACK/RESULT one cycle after that.
  bit m_ok = 0, m_busy = 0, m_to = 0, m_err = 0;
  int m_ptr = 0, m_id = 0, m_go_cyc = -1, m_resp_cyc = -1;
  logic [N-1:0] m_ack = 0;
  logic [2*W-1:0] m_res = 0;
  logic [W-1:0] m_a = 0, m_b = 0;
  always @(negedge clk) begin
    logic [N-1:0] elig, nack;
    bit nerr;
    if (m_ok) begin
      chk("busy", busy, m_busy);
      chk("mult_go", mult_go, cyc_n == m_go_cyc);
      chk("ack", ack, m_ack);
      chk("err", err, m_err);
      chk("result", result, m_res);
      chk("grant_id", grant_id, m_id);
      chk("mult_a", mult_a, m_a);
      chk("mult_b", mult_b, m_b);
    end
    nack = 0;
    nerr = 0;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_id = 0; m_res = 0; m_a = 0; m_b = 0;
      m_go_cyc = -1; m_resp_cyc = -1; m_to = 0; m_ok = 1;
    end else if (!m_busy) begin
      elig = req & ~m_ack;
      if (elig != 0 && mult_start) begin
        for (int k = N - 1; k >= 0; k--) if (elig[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
        m_busy = 1;
        m_a = req_a[m_id*W +: W];
        m_b = req_b[m_id*W +: W];
        m_go_cyc = cyc_n + 1;
        m_resp_cyc = -1;
        m_to = 0;
      end
    end else if (cyc_n == m_resp_cyc) begin
      nack[m_id] = 1;
      m_res = m_to ? 0 : mult_f;
      nerr = m_to;
      m_ptr = (m_id + 1) % N;
      m_busy = 0;
    end else if (cyc_n > m_go_cyc && m_resp_cyc < 0) begin
      if (mult_done) m_resp_cyc = cyc_n + 1;
`ifdef MULT_ARB_TIMEOUT_EN
      else if (cyc_n - m_go_cyc == TO) begin
        m_resp_cyc = cyc_n + 1;
        m_to = 1;
      end
`endif
    end
    m_ack = nack;
    m_err = nerr;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1;
    req = 0;
    cyc(2);
    rst = 0;
  endtask

  task automatic wait_go(output int c);
    int k = 0;
    while (!mult_go && k < 200) begin
      cyc();
      k++;
    end
    chk("go_seen", mult_go, 1);
    c = cyc_n;
  endtask

  task automatic wait_ack(output int c);
    int k = 0;
    while (ack == 0 && k < 200) begin
      cyc();
      k++;
    end
    chk("ack_seen", int'(ack != 0), 1);
    c = cyc_n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1);
  end

  initial begin
    int g, c;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int exp_res[5] = '{2, 4, 6, 8, 2};
    bit [N-1:0] pend, cur;
    do_reset;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_go", mult_go, 0);
    chk("rst_result", result, 0);
    chk("rst_mult_a", mult_a, 0);
    // single request
    req_a[2:0] = 3;
    req_b[2:0] = 5;
    req = 4'b0001;
    wait_go(g);
    chk("single_a", mult_a, 3);
    chk("single_b", mult_b, 5);
    cyc();
    chk("single_go_once", mult_go, 0);
    wait_ack(c);
    chk("single_ack", ack, 1);
    chk("single_res", result, 15);
    chk("single_err", err, 0);
    cyc();
    req = 0;
    // zero operand, RESULT previously 15
    req_a[8:6] = 0;
    req_b[8:6] = 6;
    req = 4'b0100;
    wait_go(g);
    wait_ack(c);
    chk("zero_latency", c - (g - 1), 4);
    chk("zero_ack", ack, 4);
    chk("zero_res", result, 0);
    cyc();
    req = 0;
    // contention
    do_reset;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 3'(i + 1);
      req_b[i*W +: W] = 2;
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(c);
      chk("rr_ack", ack, 1 << exp_id[t]);
      chk("rr_res", result, exp_res[t]);
      cyc();
    end
    // back-to-back: requester 1 still requesting in its ACK cycle loses to pending 3
    do_reset;
    req_a[5:3] = 2;
    req_b[5:3] = 3;
    req_a[11:9] = 1;
    req_b[11:9] = 7;
    req = 4'b0010;
    wait_go(g);
    chk("b2b_first", grant_id, 1);
    req = 4'b1010;
    wait_ack(c);
    chk("b2b_ack1", ack, 2);
    chk("b2b_res1", result, 6);
    wait_go(g);
    chk("b2b_next", grant_id, 3);
    start_en = 0;
    wait_ack(c);
    chk("b2b_ack3", ack, 8);
    chk("b2b_res3", result, 7);
    cyc();
    req = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("nostart_go", mult_go, 0);
      chk("nostart_busy", busy, 0);
    end
    start_en = 1;
    wait_go(g);
    chk("start_grant", grant_id, 1);
    wait_ack(c);
    cyc();
    req = 0;
    // reset while waiting on the multiplier
    hang = 1;
    req = 4'b0100;
    wait_go(g);
    cyc(3);
    chk("rw_busy_pre", busy, 1);
    rst = 1;
    cyc();
    rst = 0;
    hang = 0;
    req = 4'b0011;
    chk("rw_busy", busy, 0);
    chk("rw_ack", ack, 0);
    chk("rw_go", mult_go, 0);
    wait_ack(c);
    chk("rw_first", ack, 1);
    cyc();
    req = 4'b0010;
    wait_ack(c);
    chk("rw_second", ack, 2);
    cyc();
    req = 0;
    // multiplier never finishes
    hang = 1;
    req = 4'b0001;
    wait_go(g);
`ifdef MULT_ARB_TIMEOUT_EN
    wait_ack(c);
    chk("to_latency", c - g, TO + 2);
    chk("to_ack", ack, 1);
    chk("to_err", err, 1);
    chk("to_res", result, 0);
`else
    cyc(2 * TO);
    chk("to_busy", busy, 1);
    chk("to_noack", ack, 0);
`endif
    hang = 0;
    do_reset;
    // randomized traffic
    noise_en = 1;
    pend = 0;
    for (int t = 0; t < 4000; t++) begin
      cur = ack;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 0;
          else begin
            req_a[i*W +: W] = 3'($urandom_range(0, 7));
            req_b[i*W +: W] = 3'($urandom_range(0, 7));
          end
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1;
          req_a[i*W +: W] = 3'($urandom_range(0, 7));
          req_b[i*W +: W] = 3'($urandom_range(0, 7));
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req_a[i*W +: W] = 3'($urandom_range(0, 7));
        end
      end
      pend = cur;
      start_en = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 1499) == 0;
      cyc();
    end
    rst = 0;
    req = 0;
    start_en = 1;
    cyc(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential multiplier (controller FSM plus datapath) between NUM_REQ requesters.
- Latches the winning requester's operands and pulses the multiplier's GO.
- Waits for the multiplier's completion strobe, captures the product and returns it with a one-cycle ACK.
- Sits between client blocks and the multiplier's GO/A/B/START/LOAD_F_REG/F interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 3, operand width; product width is 2*DATA_W
- TIMEOUT_CYC, 64, WAIT-state cycle limit (used only with the optional feature)

Ports:
- SYS_CLOCK  in  1  system clock, rising edge
- SYS_SRESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester request level
- REQ_A  in  NUM_REQ*DATA_W  packed operand A; slice i belongs to requester i
- REQ_B  in  NUM_REQ*DATA_W  packed operand B
- ACK  out  NUM_REQ  one-hot, one-cycle completion pulse
- RESULT  out  2*DATA_W  product; valid only while ACK is nonzero
- ERR  out  1  timeout flag, qualified by ACK
- BUSY  out  1  arbiter is not in IDLE
- GRANT_ID  out  $clog2(NUM_REQ)  index of the current or last-served requester
- MULT_GO  out  1  one-cycle start to the multiplier
- MULT_A, MULT_B  out  DATA_W  operands to the multiplier
- MULT_START  in  1  multiplier is idle and ready for GO
- MULT_DONE  in  1  multiplier's final-register load strobe
- MULT_F  in  2*DATA_W  multiplier result; valid the cycle after MULT_DONE

Behaviour:
- Reset (synchronous, SYS_SRESET=1 at a rising edge):
  - state=IDLE, RR pointer=0, GRANT_ID=0.
  - ACK, RESULT, ERR, MULT_GO, MULT_A, MULT_B all 0.
  - Reset mid-transaction abandons it with no ACK. The multiplier is reset by the same signal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any eligible REQ and MULT_START=1, pick the winner by round-robin: search from the pointer upward, wrapping.
  - Latch the winner's REQ_A/REQ_B slices into the operand regs, set GRANT_ID, go to ISSUE.
  - Otherwise stay in IDLE. MULT_START=0 blocks all grants.
- Eligibility: REQ[i]=1 and ACK[i]=0 in the same cycle. A requester is never regranted in its own ACK cycle.
- ISSUE: MULT_GO=1 for exactly this cycle, then go to WAIT. MULT_A/MULT_B hold the latched operands from ISSUE through RESP.
- WAIT: on MULT_DONE=1, go to RESP; otherwise stay.
- RESP (one cycle):
  - At the exit edge, RESULT<=MULT_F, ACK[GRANT_ID]<=1, pointer<=(GRANT_ID+1) mod NUM_REQ, state<=IDLE.
  - ACK drops after one cycle. RESULT holds its value until the next ACK.
- Latency:
  - Let IDLE grant cycle = t and MULT_DONE cycle = d. Then ISSUE = t+1, RESP = d+1, ACK = d+2.
  - Zero operand (multiplier skips its loop, d=t+2): ACK at t+4.
- Operand changes on REQ_A/REQ_B after the grant are ignored.
- A requester dropping REQ before its ACK is a protocol violation. The transaction still completes and ACK is still issued.
- Requester protocol: hold REQ and operands until ACK; deassert or present new operands the cycle after ACK.
- BUSY=1 in ISSUE, WAIT and RESP.
- MULT_DONE outside WAIT is ignored.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - After TIMEOUT_CYC WAIT cycles with no MULT_DONE, go to RESP with timeout set.
  - ACK pulses as normal with ERR=1 and RESULT=0; the pointer advances.
- Undefined: no counter, ERR tied to 0, WAIT lasts indefinitely.

Decomposition:
- Package mult_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - default width constants;
  - the timeout counter width function.
- Sub-module mult_rr_pick: combinational round-robin picker with inputs eligible vector and pointer, outputs valid and index.

Test Plan:
- Use NUM_REQ=4, DATA_W=3 and a behavioural multiplier model.
- Single request: REQ[0], A=3, B=5 -> MULT_GO high exactly 1 cycle with MULT_A=3, MULT_B=5; ACK=4'b0001, RESULT=15, ERR=0.
- Contention: REQ=4'b1111 held after reset -> grant order 0,1,2,3,0; each ACK carries its own product (operands A=i+1, B=2 give 2,4,6,8).
- Zero operand: REQ[2] with A=0, B=6, model completes 1 cycle after GO -> ACK[2] exactly 4 cycles after the grant cycle, RESULT=0.
- Back-to-back: REQ[1] held through its ACK cycle with REQ[3] pending -> next grant is 3, not 1; MULT_START=0 in IDLE -> no MULT_GO until it rises.
- Reset in WAIT -> next cycle BUSY=0, ACK=0, MULT_GO=0; then REQ=4'b0011 -> requester 0 granted first.
- Timeout: model never asserts MULT_DONE -> with MULT_ARB_TIMEOUT_EN, ACK with ERR=1 and RESULT=0 after 64 WAIT cycles; without it, BUSY stays 1 and ACK stays 0.
